// File: rtl/param_array_streamer_pkg.sv
// Shared types and helpers for the parameter readback stream.
// Holds the burst state encoding and the index-width rule.
package param_stream_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  function automatic int dest_width(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_array_streamer_if.sv
// AXI-stream style bundle carrying one parameter entry per beat.
// Master drives data/dest/valid/tlast; slave returns ready.
interface param_array_streamer_if #(
  parameter int DW = 32,
  parameter int TW = 2
);
  logic [DW-1:0] data;
  logic [TW-1:0] dest;
  logic          valid;
  logic          ready;
  logic          tlast;

  modport master (
    output data,
    output dest,
    output valid,
    output tlast,
    input  ready
  );

  modport slave (
    input  data,
    input  dest,
    input  valid,
    input  tlast,
    output ready
  );
endinterface

// File: rtl/param_array_streamer_regfile.sv
// Parameter entry array: reloads INIT_VALUES on reset,
// range-checked write port, combinational read port.
module param_entry_regfile #(
  parameter int                              DATA_WIDTH  = 32,
  parameter int                              N_PARAMS    = 4,
  parameter int                              DEST_WIDTH  = 2,
  parameter logic [N_PARAMS*DATA_WIDTH-1:0]  INIT_VALUES = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DEST_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DEST_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [N_PARAMS];
  logic                  wr_ok;

  assign wr_ok = (int'(wr_addr) < N_PARAMS);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_PARAMS; i++) begin
        mem[i] <= INIT_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (wr_valid && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_array_streamer.sv
// Streams the parameter entry array as one burst per start,
// tdest = entry index, tlast on the final entry.
module param_array_streamer
  import param_stream_pkg::*;
#(
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             N_PARAMS    = 4,
  parameter int                             DEST_WIDTH  = dest_width(N_PARAMS),
  parameter logic [N_PARAMS*DATA_WIDTH-1:0] INIT_VALUES = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  wr_valid,
  input  logic [DEST_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [DEST_WIDTH-1:0] m_dest,
  output logic                  m_tlast
);

  localparam logic [DEST_WIDTH-1:0] LAST = DEST_WIDTH'(N_PARAMS - 1);

  param_array_streamer_if #(
    .DW(DATA_WIDTH),
    .TW(DEST_WIDTH)
  ) axis ();

  state_e                state_q, state_d;
  logic [DEST_WIDTH-1:0] idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  hs;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  tlast_q;
  logic                  valid;

  param_entry_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_PARAMS   (N_PARAMS),
    .DEST_WIDTH (DEST_WIDTH),
    .INIT_VALUES(INIT_VALUES)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  assign hs = valid & axis.ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Start is ignored in the done cycle as well as while sending.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = SEND;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + DEST_WIDTH'(1);
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat is captured on load so later entry writes cannot disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      dest_q  <= '0;
      tlast_q <= 1'b0;
    end else if (load) begin
      data_q  <= rd_data;
      dest_q  <= idx_d;
      tlast_q <= (idx_d == LAST);
    end else if (done_d) begin
      data_q  <= '0;
      dest_q  <= '0;
      tlast_q <= 1'b0;
    end
  end

  always_comb begin
    valid = (state_q == SEND);
    busy  = (state_q == SEND);
    done  = done_q;
  end

  assign axis.data  = data_q;
  assign axis.dest  = dest_q;
  assign axis.valid = valid;
  assign axis.tlast = tlast_q;
  assign axis.ready = m_ready;

  assign m_data  = axis.data;
  assign m_dest  = axis.dest;
  assign m_valid = axis.valid;
  assign m_tlast = axis.tlast;

endmodule

// File: tb/tb_param_array_streamer.sv
// Directed bench for param_array_streamer: N_PARAMS=4 main
// instance plus N_PARAMS=1 and N_PARAMS=3 edge instances.
module tb_param_array_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  param_array_streamer_if #(.DW(32), .TW(2)) axis ();

  logic        start, busy, done;
  logic        wr_valid;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;

  param_array_streamer #(
    .DATA_WIDTH (32),
    .N_PARAMS   (4),
    .DEST_WIDTH (2),
    .INIT_VALUES({32'd8, 32'h3F, 32'd32, 32'd5})
  ) dut (
    .clock   (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .m_valid (axis.valid),
    .m_ready (axis.ready),
    .m_data  (axis.data),
    .m_dest  (axis.dest),
    .m_tlast (axis.tlast)
  );

  logic        start1, busy1, done1, valid1, tlast1;
  logic [0:0]  dest1;
  logic [31:0] data1;

  param_array_streamer #(
    .DATA_WIDTH (32),
    .N_PARAMS   (1),
    .DEST_WIDTH (1),
    .INIT_VALUES(32'h2A)
  ) dut1 (
    .clock   (clk),
    .reset   (reset),
    .start   (start1),
    .busy    (busy1),
    .done    (done1),
    .wr_valid(1'b0),
    .wr_addr (1'b0),
    .wr_data (32'd0),
    .m_valid (valid1),
    .m_ready (1'b1),
    .m_data  (data1),
    .m_dest  (dest1),
    .m_tlast (tlast1)
  );

  logic        start3, busy3, done3, valid3, tlast3;
  logic        wr_valid3;
  logic [1:0]  wr_addr3, dest3;
  logic [31:0] wr_data3, data3;

  param_array_streamer #(
    .DATA_WIDTH (32),
    .N_PARAMS   (3),
    .DEST_WIDTH (2),
    .INIT_VALUES({32'h33, 32'h22, 32'h11})
  ) dut3 (
    .clock   (clk),
    .reset   (reset),
    .start   (start3),
    .busy    (busy3),
    .done    (done3),
    .wr_valid(wr_valid3),
    .wr_addr (wr_addr3),
    .wr_data (wr_data3),
    .m_valid (valid3),
    .m_ready (1'b1),
    .m_data  (data3),
    .m_dest  (dest3),
    .m_tlast (tlast3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] d,
                      input int idx, input logic last);
    chk({tag, " valid"}, 64'(axis.valid), 64'd1);
    chk({tag, " data"},  64'(axis.data),  64'(d));
    chk({tag, " dest"},  64'(axis.dest),  64'(idx));
    chk({tag, " tlast"}, 64'(axis.tlast), 64'(last));
  endtask

  task automatic burst(input string tag,
                       input logic [31:0] d0, d1, d2, d3,
                       input int sb, input int ns);
    logic [31:0] exp [4];
    int busy_n;
    exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
    busy_n = 0;
    axis.ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      beat($sformatf("%s b%0d", tag, b), exp[b], b, b == 3);
      if (busy) busy_n++;
      if (b == sb) begin
        axis.ready = 1'b0;
        for (int s = 0; s < ns; s++) begin
          step();
          beat($sformatf("%s hold%0d", tag, s), exp[b], b, b == 3);
          if (busy) busy_n++;
        end
        axis.ready = 1'b1;
      end
      step();
    end
    chk({tag, " end valid"}, 64'(axis.valid), 64'd0);
    chk({tag, " end tlast"}, 64'(axis.tlast), 64'd0);
    chk({tag, " end busy"},  64'(busy), 64'd0);
    chk({tag, " done"},      64'(done), 64'd1);
    chk({tag, " busy cyc"},  64'(busy_n), 64'(4 + ns));
    step();
    chk({tag, " done drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; start1 = 1'b0; start3 = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    wr_valid3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
    axis.ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    chk("rst valid", 64'(axis.valid), 64'd0);
    chk("rst busy",  64'(busy), 64'd0);
    chk("rst done",  64'(done), 64'd0);
    chk("rst data",  64'(axis.data), 64'd0);
    chk("rst dest",  64'(axis.dest), 64'd0);
    chk("rst tlast", 64'(axis.tlast), 64'd0);

    burst("full", 32'd5, 32'd32, 32'h3F, 32'd8, -1, 0);
    burst("bp", 32'd5, 32'd32, 32'h3F, 32'd8, 1, 3);

    start = 1'b1;
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 32'd7;
    step();
    start = 1'b0;
    beat("wr b0", 32'd5, 0, 1'b0);
    axis.ready = 1'b0;
    wr_addr = 2'd3; wr_data = 32'd99;
    step();
    beat("wr hold", 32'd5, 0, 1'b0);
    wr_valid = 1'b0;
    axis.ready = 1'b1;
    step();
    beat("wr b1", 32'd32, 1, 1'b0);
    step();
    beat("wr b2", 32'h3F, 2, 1'b0);
    step();
    beat("wr b3", 32'd99, 3, 1'b1);
    step();
    chk("wr done", 64'(done), 64'd1);
    step();
    burst("wr next", 32'd7, 32'd32, 32'h3F, 32'd99, -1, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    beat("ign b0", 32'd7, 0, 1'b0);
    step();
    start = 1'b1;
    beat("ign b1", 32'd32, 1, 1'b0);
    step();
    beat("ign b2", 32'h3F, 2, 1'b0);
    step();
    start = 1'b0;
    beat("ign b3", 32'd99, 3, 1'b1);
    step();
    chk("ign done", 64'(done), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign valid", 64'(axis.valid), 64'd0);
    chk("ign busy",  64'(busy), 64'd0);
    chk("ign done2", 64'(done), 64'd0);
    step();
    chk("ign idle", 64'(axis.valid), 64'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    beat("mid b0", 32'd7, 0, 1'b0);
    step();
    beat("mid b1", 32'd32, 1, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid valid", 64'(axis.valid), 64'd0);
    chk("mid busy",  64'(busy), 64'd0);
    chk("mid done",  64'(done), 64'd0);
    step();
    chk("mid stay",  64'(axis.valid), 64'd0);
    burst("post rst", 32'd5, 32'd32, 32'h3F, 32'd8, -1, 0);

    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("n1 valid", 64'(valid1), 64'd1);
    chk("n1 data",  64'(data1), 64'h2A);
    chk("n1 dest",  64'(dest1), 64'd0);
    chk("n1 tlast", 64'(tlast1), 64'd1);
    step();
    chk("n1 end",   64'(valid1), 64'd0);
    chk("n1 done",  64'(done1), 64'd1);

    wr_valid3 = 1'b1; wr_addr3 = 2'd3; wr_data3 = 32'hDEAD;
    step();
    wr_valid3 = 1'b0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("n3 valid%0d", b), 64'(valid3), 64'd1);
      chk($sformatf("n3 data%0d", b),  64'(data3), 64'(32'h11 * (b + 1)));
      chk($sformatf("n3 dest%0d", b),  64'(dest3), 64'(b));
      chk($sformatf("n3 tlast%0d", b), 64'(tlast3), 64'(b == 2));
      step();
    end
    chk("n3 end",  64'(valid3), 64'd0);
    chk("n3 done", 64'(done3), 64'd1);
    step();
    chk("n3 idle", 64'(valid3), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/param_array_streamer.md
Name: param_array_streamer

Overview:
- Holds a runtime-writable array of N_PARAMS parameter words, preloaded from an elaboration-time parameter array.
- On a start pulse, streams the whole array out as an AXI-stream burst: one beat per entry, tdest = entry index, tlast on the final entry.
- This is the readback end of the parameter path. Software or the control bus writes entries; downstream stream consumers receive the full set in index order.

Parameters:
- DATA_WIDTH, 32, width of each entry and of m_data.
- N_PARAMS, 4, number of entries; must be ≥1.
- DEST_WIDTH, ($clog2(N_PARAMS) > 0 ? $clog2(N_PARAMS) : 1), width of wr_addr and m_dest.
- INIT_VALUES, {N_PARAMS*DATA_WIDTH{1'b0}}, packed reset contents; entry i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle burst request.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last handshake.
- done  out  1  one-cycle pulse in the cycle after the last handshake.
- wr_valid  in  1  entry write strobe.
- wr_addr  in  DEST_WIDTH  entry index to write.
- wr_data  in  DATA_WIDTH  value to write.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  DATA_WIDTH  entry value.
- m_dest  out  DEST_WIDTH  entry index.
- m_tlast  out  1  high on the beat for index N_PARAMS-1.

Behaviour:
- Reset (synchronous, active-high):
  - Entry array reloads from INIT_VALUES.
  - Index counter = 0, state = IDLE.
  - m_valid, m_tlast, busy, done = 0; m_data, m_dest = 0.
  - Reset asserted mid-burst aborts the burst immediately; nothing resumes afterwards.
- State machine:
  - IDLE: start=1 → SEND. In the next cycle m_valid=1, m_data=entry[0], m_dest=0, busy=1 (latency 1 cycle).
  - SEND, handshake (m_valid & m_ready) with index < N_PARAMS-1: index increments. The next cycle presents entry[index+1] with no bubble, giving one beat per cycle when m_ready is held high.
  - SEND, handshake at index = N_PARAMS-1: → IDLE. Next cycle m_valid=0, m_tlast=0, busy=0, done=1 for one cycle.
  - SEND, no handshake: m_data, m_dest and m_tlast hold stable; m_valid stays high (AXI-stream rule, never withdrawn).
- start while busy or in the done cycle: ignored.
- start in the cycle after done: accepted normally.
- N_PARAMS=1: the single beat carries m_tlast=1.
- Output register: m_data is taken from the entry array into an output register when a beat is loaded. Entry writes never alter a beat already presented.
- Writes:
  - wr_valid=1 updates entry[wr_addr] at the clock edge, in any state.
  - wr_addr ≥ N_PARAMS: ignored.
  - A write to an index not yet presented in the current burst appears in that burst.
  - A write to the index presented in the same cycle it loads into the output register: the old value is streamed; the new value is stored.
- Index counter: DEST_WIDTH bits, compared against N_PARAMS-1. It never wraps past N_PARAMS-1 for non-power-of-two N_PARAMS.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
- Shared package param_stream_pkg holds:
  - state enum (IDLE, SEND);
  - function dest_width(n) returning max($clog2(n),1).
- Stream ports map field-for-field onto the codebase AXI-stream interface (data, dest, valid, ready, tlast). The block exposes plain ports; the top wraps them.
- One natural sub-module: param_entry_regfile. It contains the entry array, the INIT_VALUES reload, the write port with range check, and a combinational read port.

Test Plan:
- Reset, idle, full burst: N_PARAMS=4, INIT_VALUES entries {5, 32, 'h3F, 8}; start with m_ready=1 → four consecutive beats (data,dest) = (5,0), (32,1), ('h3F,2), (8,3). tlast only on beat 3; done pulses in the following cycle; busy is high for exactly 4 cycles.
- Backpressure: m_ready low for 3 cycles on beat 1 → m_data=32 and m_dest=1 held stable with m_valid high; total burst takes 7 cycles; beat order unchanged.
- Write during burst: write entry[3]=99 while beat 0 stalls → beat 3 carries 99. Write entry[0]=7 while beat 0 is presented → beat 0 still carries 5; the next burst carries 7.
- Start ignored: pulse start during beats 1 and 2 and in the done cycle → exactly 4 beats total, one done pulse.
- Reset mid-burst: assert reset after beat 1 handshake → next cycle m_valid=0, busy=0, entries equal INIT_VALUES. A new start produces beats from index 0.
- Edge configs: N_PARAMS=1, INIT_VALUES='h2A → one beat with data 'h2A, dest 0, tlast=1. N_PARAMS=3 with wr_addr=3 write → ignored, and no beat with dest 3 ever appears.
